register_file: RTL and testbench
================================

# register_file

32-entry × 32-bit general-purpose register file for the RISC-V core datapath, sitting between decode and execute. Provides two combinational read ports (rs1, rs2) and one synchronous write port (rd). Register x0 is hardwired to zero. All registers clear on reset.

## Interface

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index; depth = 2^ADDR_WIDTH (32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- rs1  input  ADDR_WIDTH  read-port-1 register index.
- rs2  input  ADDR_WIDTH  read-port-2 register index.
- rd  input  ADDR_WIDTH  write register index.
- regWrite  input  1  write enable, active-high.
- writeData  input  DATA_WIDTH  data to write into register rd.
- readData1  output  DATA_WIDTH  contents of register rs1.
- readData2  output  DATA_WIDTH  contents of register rs2.

## Operation

- Storage: registers x1..x31, each DATA_WIDTH bits. x0 has no storage and always reads 0.
- Reset: while rst = 0, every register x1..x31 is forced to 0, independent of clk. Both read outputs then return 0 for any index.
- Write: on a rising clk edge with rst = 1, regWrite = 1 and rd ≠ 0, register[rd] is loaded with writeData.
- If regWrite = 0 or rd = 0, no register changes. Writes to x0 are silently discarded.
- Read: readData1 = (rs1 == 0) ? 0 : register[rs1]. readData2 follows the same rule with rs2. Both reads are purely combinational.
- Both ports may read the same index at the same time, including x0. Each returns the same value.
- Only one write can happen per cycle. There are no multi-write conflicts.
- No undefined values: every index in 0..31 is valid, and every register reads a defined value after the first reset.

## Timing

- Write latency: 1 clock. Data written at edge N is visible on the read outputs right after edge N (combinational propagation only).
- Read latency: 0 cycles. Outputs track rs1, rs2 and register contents combinationally.
- Same-cycle read of rd while a write is pending:
  - Without bypass, the old value is returned until the edge.
  - With bypass, see Configuration.
- Reset asserted mid-operation:
  - Register contents clear immediately, without waiting for a clock edge.
  - A write coincident with the reset edge is lost.
- Reset release: the first write can occur at the first rising edge after rst returns to 1.

## Configuration

- Macro: REGFILE_BYPASS_EN.
- When defined, write-to-read forwarding is added. If regWrite = 1, rd ≠ 0 and rsN == rd, then readDataN = writeData in the same cycle, before the edge. Forwarding is disabled while rst = 0.
- When undefined, reads return the stored value only. The new value appears after the write edge.
- x0 reads 0 in both modes.

## Test plan

- Reset: hold rst = 0 after writing 0xDEADBEEF to x5. Require readData1 = 0 for rs1 = 5 immediately, before any clk edge.
- Basic write/read: rst = 1, rd = 1, writeData = 0xA5A5A5A5, regWrite = 1, one edge. Then rs1 = 1, rs2 = 0. Require readData1 = 0xA5A5A5A5 and readData2 = 0x00000000.
- Second register: rd = 2, writeData = 0x12345678, one edge. Then rs1 = 1, rs2 = 2. Require 0xA5A5A5A5 and 0x12345678 respectively.
- x0 write ignored: rd = 0, writeData = 0xFFFFFFFF, regWrite = 1, one edge. Require readData1 = 0 for rs1 = 0. Require x1 and x2 unchanged.
- Write disable: regWrite = 0, rd = 3, writeData = 0x55AA55AA, one edge. Require x3 to still read 0.
- Bypass and sweep:
  - With REGFILE_BYPASS_EN, rd = rs1 = 7, writeData = 0x0BADF00D, regWrite = 1. Require readData1 = 0x0BADF00D before the edge.
  - Without the macro, require the old value before the edge and the new value after.
  - Write index i to register i for all 1..31, then read back through both ports. Require exact match.

Source files
------------

// File: rtl/register_file.sv
// 32 x 32 RISC-V register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  regWrite,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_en;
  logic                  fwd1;
  logic                  fwd2;

  assign write_en = regWrite && (rd != '0);

  // Entry 0 is only ever cleared, so it stays zero; reads still mask it explicitly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[rd] <= writeData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = rst && write_en && (rd == rs1);
  assign fwd2 = rst && write_en && (rd == rs2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign readData1 = (rs1 == '0) ? '0 : (fwd1 ? writeData : regs[rs1]);
  assign readData2 = (rs2 == '0) ? '0 : (fwd2 ? writeData : regs[rs2]);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed literal checks plus randomized traffic against an array model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        regWrite;
  logic [31:0] writeData;
  logic [31:0] readData1, readData2;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .regWrite(regWrite), .writeData(writeData),
    .readData1(readData1), .readData2(readData2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: plain array of architectural register values.
  logic [31:0] model [32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
    end else if (regWrite && rd != 5'd0) begin
      model[rd] <= writeData;
    end
  end

  function automatic logic [31:0] expv(input logic [4:0] idx);
    if (!rst || idx == 5'd0) return 32'h0;
    if (BYPASS && regWrite && rd != 5'd0 && rd == idx) return writeData;
    return model[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_rd1", readData1, expv(rs1));
    chk("model_rd2", readData2, expv(rs2));
  end

  // Advance to just after the next rising edge and apply new inputs.
  task automatic cyc(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] w,
                     input logic we, input logic [31:0] d);
    @(posedge clk);
    #2;
    rs1 = a1; rs2 = a2; rd = w; regWrite = we; writeData = d;
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; regWrite = 1'b0; writeData = 32'h0;
    #5;
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    chk("reset_rd1", readData1, 32'h0);
    chk("reset_rd2", readData2, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Asynchronous reset clears stored data without a clock edge.
    cyc(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF);
    cyc(5'd5, 5'd0, 5'd0, 1'b0, 32'h0);
    chk("pre_reset_x5", readData1, 32'hDEADBEEF);
    #2 rst = 1'b0;
    #1 chk("async_reset_x5", readData1, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;

    cyc(5'd0, 5'd0, 5'd1, 1'b1, 32'hA5A5A5A5);
    cyc(5'd1, 5'd0, 5'd0, 1'b0, 32'h0);
    chk("basic_x1", readData1, 32'hA5A5A5A5);
    chk("basic_x0", readData2, 32'h0);

    cyc(5'd0, 5'd0, 5'd2, 1'b1, 32'h12345678);
    cyc(5'd1, 5'd2, 5'd0, 1'b0, 32'h0);
    chk("second_x1", readData1, 32'hA5A5A5A5);
    chk("second_x2", readData2, 32'h12345678);

    cyc(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF);
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    chk("x0_write_rd1", readData1, 32'h0);
    chk("x0_write_rd2", readData2, 32'h0);
    cyc(5'd1, 5'd2, 5'd0, 1'b0, 32'h0);
    chk("x0_write_x1", readData1, 32'hA5A5A5A5);
    chk("x0_write_x2", readData2, 32'h12345678);

    cyc(5'd0, 5'd0, 5'd3, 1'b0, 32'h55AA55AA);
    cyc(5'd3, 5'd3, 5'd0, 1'b0, 32'h0);
    chk("write_dis_x3", readData1, 32'h0);

    // Same-cycle read of the register being written.
    cyc(5'd0, 5'd0, 5'd7, 1'b1, 32'h11111111);
    cyc(5'd7, 5'd7, 5'd7, 1'b1, 32'h0BADF00D);
    chk("same_cycle_rd1", readData1, BYPASS ? 32'h0BADF00D : 32'h11111111);
    chk("same_cycle_rd2", readData2, BYPASS ? 32'h0BADF00D : 32'h11111111);
    cyc(5'd7, 5'd0, 5'd0, 1'b0, 32'h0);
    chk("after_edge_x7", readData1, 32'h0BADF00D);

    // Sweep: register i holds i.
    for (int i = 1; i < 32; i++) cyc(5'd0, 5'd0, 5'(i), 1'b1, 32'(i));
    for (int i = 1; i < 32; i++) begin
      cyc(5'(i), 5'(32 - i), 5'd0, 1'b0, 32'h0);
      chk("sweep_rd1", readData1, 32'(i));
      chk("sweep_rd2", readData2, 32'(32 - i));
    end

    // Randomized traffic, including occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] w;
      @(posedge clk);
      #2;
      rst = ($urandom_range(0, 149) != 0);
      w = 5'($urandom_range(0, 31));
      rd = w;
      regWrite = ($urandom_range(0, 3) != 0);
      writeData = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
    end
    @(posedge clk);
    #2 rst = 1'b1; regWrite = 1'b0;
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
